// File: rtl/sdu_uart_probe_pkg.sv
// Shared types and helpers for the passive UART line monitor: receiver state
// encoding, FIFO record width and the mid-bit sampling offset.
package sdu_uart_probe_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    localparam int TIMER_W = 16;

    // History record is {channel tag, byte}.
    function automatic int rec_width(input int chw);
        return chw + 8;
    endfunction

    function automatic logic [TIMER_W-1:0] mid_bit(input int div);
        return TIMER_W'(div / 2);
    endfunction

endpackage

// File: rtl/uart_rx_sniff.sv
// Single-line UART sniffer: synchroniser, bit timer and frame FSM.
// good/frm are single-cycle pulses in the stop-sample cycle; rx_byte is valid with them.
module uart_rx_sniff
    import sdu_uart_probe_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       line,
    output logic [7:0] rx_byte,
    output logic       good,
    output logic       frm,
    output rx_state_e  state
);

    localparam logic [TIMER_W-1:0] HALF = mid_bit(DIV);
    localparam logic [TIMER_W-1:0] FULL = TIMER_W'(DIV);

    logic               sync1;
    logic               rx;
    logic [1:0]         fill;
    logic               armed;
    logic               armed_nxt;
    rx_state_e          state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [3:0]         bit_idx;
    logic [3:0]         idx_nxt;
    logic [7:0]         shreg;
    logic [7:0]         sh_nxt;

    // fill marks when the synchroniser holds real line samples rather than reset values;
    // armed then requires the line to be seen idle before any start is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
            fill  <= 2'b00;
        end else begin
            sync1 <= line;
            rx    <= sync1;
            fill  <= {fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= RX_IDLE;
            armed   <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            armed   <= armed_nxt;
            timer   <= timer_nxt;
            bit_idx <= idx_nxt;
            shreg   <= sh_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        armed_nxt = armed;
        timer_nxt = timer + 1'b1;
        idx_nxt   = bit_idx;
        sh_nxt    = shreg;
        good      = 1'b0;
        frm       = 1'b0;
        case (state)
            RX_IDLE: begin
                timer_nxt = TIMER_W'(1);
                if (!armed) begin
                    armed_nxt = fill[1] & rx;
                end else if (!rx) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (timer == HALF) begin
                    if (rx) begin
                        state_nxt = RX_IDLE;
                    end else begin
                        state_nxt = RX_DATA;
                        timer_nxt = TIMER_W'(1);
                        idx_nxt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (timer == FULL) begin
                    timer_nxt = TIMER_W'(1);
                    sh_nxt    = {rx, shreg[7:1]};
                    idx_nxt   = bit_idx + 4'd1;
                    if (bit_idx == 4'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (timer == FULL) begin
                    if (rx) begin
                        good      = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        frm       = 1'b1;
                        state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/sdu_uart_probe.sv
// Passive multi-line UART monitor: per-channel last byte, sticky framing errors and a
// channel-tagged first-word-fall-through history FIFO fed by a lowest-index-first arbiter.
module sdu_uart_probe
    import sdu_uart_probe_pkg::*;
#(
    parameter int DIV   = 868,
    parameter int NCH   = 2,
    parameter int DEPTH = 16,
    parameter int CHW   = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NCH-1:0]     line,
    input  logic               clr,
    output logic [8*NCH-1:0]   last_byte,
    output logic [NCH-1:0]     byte_vld,
    output logic [NCH-1:0]     frm_err,
    input  logic               rd_en,
    output logic [CHW+7:0]     rd_data,
    output logic               empty,
    output logic               full,
    output logic [7:0]         drop_cnt,
    output logic [3*NCH-1:0]   rx_state
);

    localparam int RW = rec_width(CHW);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]     rx_byte [NCH];
    logic [NCH-1:0] good;
    logic [NCH-1:0] frm;
    rx_state_e      st [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_rx
        uart_rx_sniff #(.DIV(DIV)) u_rx (
            .clk     (clk),
            .rstn    (rstn),
            .line    (line[i]),
            .rx_byte (rx_byte[i]),
            .good    (good[i]),
            .frm     (frm[i]),
            .state   (st[i])
        );
        assign rx_state[3*i +: 3] = st[i];
    end

    logic [NCH-1:0] pend;
    logic [NCH-1:0] sel_oh;
    logic [CHW-1:0] sel_idx;
    logic [7:0]     sel_byte;
    logic           push_req;
    logic [RW-1:0]  push_data;

    // A pending channel's byte is still in last_byte: the next frame is >= 10 bit-times away.
    always_comb begin
        sel_oh   = '0;
        sel_idx  = '0;
        sel_byte = '0;
        push_req = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_idx   = CHW'(i);
                sel_byte  = last_byte[8*i +: 8];
                push_req  = 1'b1;
            end
        end
    end

    assign push_data = {sel_idx, sel_byte};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_byte <= '1;
            byte_vld  <= '0;
            frm_err   <= '0;
            pend      <= '0;
        end else begin
            byte_vld <= good;
            for (int i = 0; i < NCH; i++) begin
                if (good[i]) last_byte[8*i +: 8] <= rx_byte[i];
            end
            pend    <= (pend & ~sel_oh) | good;
            frm_err <= clr ? '0 : (frm_err | frm);
        end
    end

    logic [RW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   wptr_n;
    logic [AW:0]   rptr_n;
    logic [AW:0]   cnt_n;
    logic          pop_ok;
    logic          push_ok;
    logic          drop;
    logic          empty_n;
    logic [RW-1:0] head;

    // When full, a simultaneous pop frees the slot the push needs.
    always_comb begin
        pop_ok  = rd_en & ~empty & ~clr;
        push_ok = push_req & ~clr & (~full | pop_ok);
        drop    = push_req & ~clr & full & ~pop_ok;
        wptr_n  = clr ? '0 : wptr + (AW+1)'(push_ok);
        rptr_n  = clr ? '0 : rptr + (AW+1)'(pop_ok);
        cnt_n   = wptr_n - rptr_n;
        empty_n = (cnt_n == '0);
        head    = (rptr_n == wptr) ? push_data : mem[rptr_n[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wptr    <= wptr_n;
            rptr    <= rptr_n;
            rd_data <= empty_n ? '0 : head;
            empty   <= empty_n;
            full    <= cnt_n[AW];
            if (clr) begin
                drop_cnt <= '0;
            end else if (drop && drop_cnt != 8'hff) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
